// File: rtl/array_mult_pipe.sv
// Pipelined signed/unsigned array multiplier with a valid/ready stream on both sides.
// An input register stage is followed by WIDTH/ROWS_PER_STAGE accumulate stages.
module array_mult_pipe #(
  parameter int WIDTH          = 4,
  parameter int ROWS_PER_STAGE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     m,
  input  logic [WIDTH-1:0]     q,
  input  logic                 sgn,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p
);
  localparam int S  = WIDTH / ROWS_PER_STAGE;
  localparam int PW = 2 * WIDTH;

  generate
    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
      $error("array_mult_pipe: WIDTH must be in 2..16");
    end
    if (WIDTH % ROWS_PER_STAGE != 0) begin : g_bad_rows
      $error("array_mult_pipe: WIDTH must be divisible by ROWS_PER_STAGE");
    end
  endgenerate

  // Handshake: a beat moves on an edge where valid && ready. The whole pipeline
  // advances together; when the output is held, every stage holds.
  logic              v_r   [0:S];
  logic [PW-1:0]     acc_r [0:S];
  logic              sg_r  [0:S-1];
  logic [WIDTH-1:0]  m_r   [0:S-1];
  logic [WIDTH-1:0]  q_r   [0:S-1];
  logic [PW-1:0]     acc_nxt [1:S];
  logic              advance;

  assign advance   = !v_r[S] || out_ready;
  assign in_ready  = advance;
  assign out_valid = v_r[S];
  assign p         = acc_r[S];

  // Rows are sign-extended multiplicand copies; in signed mode the multiplier's
  // top bit carries weight -2^(WIDTH-1), so that row is subtracted.
  always_comb begin
    logic [PW-1:0]    mext;
    logic [PW-1:0]    sum;
    logic [WIDTH-1:0] qb;
    int               row;
    mext = '0;
    sum  = '0;
    qb   = '0;
    row  = 0;
    for (int k = 1; k <= S; k++) begin
      mext = sg_r[k-1] ? {{WIDTH{m_r[k-1][WIDTH-1]}}, m_r[k-1]}
                       : {{WIDTH{1'b0}}, m_r[k-1]};
      sum  = acc_r[k-1];
      for (int r = 0; r < ROWS_PER_STAGE; r++) begin
        row = (k - 1) * ROWS_PER_STAGE + r;
        qb  = q_r[k-1] >> row;
        if (qb[0]) begin
          if (sg_r[k-1] && row == WIDTH - 1) sum = sum - (mext << row);
          else                               sum = sum + (mext << row);
        end
      end
      acc_nxt[k] = sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= S; k++) begin
        v_r[k]   <= 1'b0;
        acc_r[k] <= '0;
      end
      for (int k = 0; k < S; k++) begin
        sg_r[k] <= 1'b0;
        m_r[k]  <= '0;
        q_r[k]  <= '0;
      end
    end else if (advance) begin
      v_r[0]   <= in_valid;
      sg_r[0]  <= sgn;
      m_r[0]   <= m;
      q_r[0]   <= q;
      acc_r[0] <= '0;
      for (int k = 1; k <= S; k++) begin
        v_r[k]   <= v_r[k-1];
        acc_r[k] <= acc_nxt[k];
      end
      for (int k = 1; k < S; k++) begin
        sg_r[k] <= sg_r[k-1];
        m_r[k]  <= m_r[k-1];
        q_r[k]  <= q_r[k-1];
      end
    end
  end
endmodule
